// File: rtl/clock_group_reset_sequencer.sv
// rtl/clock_group_reset_sequencer.sv - power-on and partial reset sequencer for one clock group
// Optional clock-gate quiesce/resume phases: define CLOCK_GROUP_SEQ_GATE_EN.
module clock_group_reset_sequencer #(
  parameter int NUM_MEMBERS    = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int GATE_CYCLES    = 2,
  parameter int CNT_W          = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic [NUM_MEMBERS-1:0] req_mask,
  output logic                   req_ready,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_MEMBERS-1:0] member_reset,
  output logic [NUM_MEMBERS-1:0] member_clock_en
);

  typedef enum logic [2:0] {
    S_BOOT    = 3'd0,
    S_IDLE    = 3'd1,
    S_QUIESCE = 3'd2,
    S_HOLD    = 3'd3,
    S_RELEASE = 3'd4,
    S_RESUME  = 3'd5,
    S_DONE    = 3'd6
  } state_t;

`ifdef CLOCK_GROUP_SEQ_GATE_EN
  localparam bit GATE_EN = 1'b1;
`else
  localparam bit GATE_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0]       HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]       STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0]       GATE_LOAD    = CNT_W'(GATE_CYCLES - 1);
  localparam logic [NUM_MEMBERS-1:0] ONE          = NUM_MEMBERS'(1);

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [NUM_MEMBERS-1:0] r_target;
  logic [NUM_MEMBERS-1:0] r_member_reset;

  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [NUM_MEMBERS-1:0] w_target_nxt;
  logic [NUM_MEMBERS-1:0] w_reset_nxt;
  logic [NUM_MEMBERS-1:0] w_pending;
  logic [NUM_MEMBERS-1:0] w_low;
  logic                   w_cnt_zero;

  // Targets still held in reset; the lowest one is the next to release.
  assign w_pending  = r_target & r_member_reset;
  assign w_low      = w_pending & ~(w_pending - ONE);
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= S_BOOT;
      r_cnt          <= '0;
      r_target       <= '1;
      r_member_reset <= '1;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_target       <= w_target_nxt;
      r_member_reset <= w_reset_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_target_nxt = r_target;
    w_reset_nxt  = r_member_reset;
    case (r_state)
      S_BOOT: begin
        w_state_nxt  = S_HOLD;
        w_cnt_nxt    = HOLD_LOAD;
        w_target_nxt = '1;
        w_reset_nxt  = '1;
      end
      S_IDLE: begin
        if (req_valid) begin
          w_target_nxt = req_mask;
          if (req_mask == '0) begin
            w_state_nxt = S_DONE;
          end else if (GATE_EN) begin
            w_state_nxt = S_QUIESCE;
            w_cnt_nxt   = GATE_LOAD;
          end else begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = HOLD_LOAD;
            w_reset_nxt = r_member_reset | req_mask;
          end
        end
      end
      S_QUIESCE: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = HOLD_LOAD;
          w_reset_nxt = r_member_reset | r_target;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_HOLD: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_RELEASE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_RELEASE: begin
        if (w_cnt_zero) begin
          w_reset_nxt = r_member_reset & ~w_low;
          w_cnt_nxt   = STAGGER_LOAD;
          if ((w_pending & ~w_low) == '0) begin
            if (GATE_EN) begin
              w_state_nxt = S_RESUME;
              w_cnt_nxt   = GATE_LOAD;
            end else begin
              w_state_nxt = S_DONE;
            end
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_RESUME: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  assign req_ready    = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign member_reset = r_member_reset;

`ifdef CLOCK_GROUP_SEQ_GATE_EN
  assign member_clock_en = ((r_state == S_QUIESCE) || (r_state == S_RESUME)) ? ~r_target : '1;
`else
  assign member_clock_en = '1;
`endif

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// tb/tb_clock_group_reset_sequencer.sv - directed checks for clock_group_reset_sequencer (default build)
module tb_clock_group_reset_sequencer;

  logic       clock;
  logic       reset;
  logic       req_valid;
  logic [3:0] req_mask;
  logic       req_ready;
  logic       busy;
  logic       done;
  logic [3:0] member_reset;
  logic [3:0] member_clock_en;

  int n_checks = 0;
  int n_errors = 0;

  clock_group_reset_sequencer #(
    .NUM_MEMBERS   (4),
    .HOLD_CYCLES   (16),
    .STAGGER_CYCLES(4),
    .GATE_CYCLES   (2),
    .CNT_W         (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_mask       (req_mask),
    .req_ready      (req_ready),
    .busy           (busy),
    .done           (done),
    .member_reset   (member_reset),
    .member_clock_en(member_clock_en)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Called while in the BOOT cycle; walks the full power-on release.
  task automatic boot_check(input string pfx);
    int dones = 0;
    for (int k = 1; k <= 31; k++) begin
      tick();
      if (done) dones++;
      if (k == 16) check({pfx, "_hold_busy"}, busy, 1);
      if (k == 17) check({pfx, "_r17"}, member_reset, 4'b1111);
      if (k == 18) check({pfx, "_r18"}, member_reset, 4'b1110);
      if (k == 22) check({pfx, "_r22"}, member_reset, 4'b1100);
      if (k == 26) check({pfx, "_r26"}, member_reset, 4'b1000);
      if (k == 30) begin
        check({pfx, "_r30"}, member_reset, 4'b0000);
        check({pfx, "_done30"}, done, 1);
      end
      if (k == 31) begin
        check({pfx, "_ready31"}, req_ready, 1);
        check({pfx, "_busy31"}, busy, 0);
      end
    end
    check({pfx, "_done_count"}, dones, 1);
  endtask

  initial begin
    int hi0, hi1, hi2, hi3, dones, done_at;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_mask  = 4'b0000;
    #3;
    check("rst_member_reset", member_reset, 4'b1111);
    check("rst_clock_en", member_clock_en, 4'b1111);
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    boot_check("boot");
    check("boot_clock_en", member_clock_en, 4'b1111);

    // Partial reset of members 0 and 2.
    req_mask  = 4'b0101;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    hi0 = 0; hi1 = 0; hi2 = 0; hi3 = 0; dones = 0; done_at = 0;
    for (int j = 1; j <= 23; j++) begin
      if (member_reset[0]) hi0++;
      if (member_reset[1]) hi1++;
      if (member_reset[2]) hi2++;
      if (member_reset[3]) hi3++;
      if (done) begin
        dones++;
        done_at = j;
      end
      if (j == 18) check("m5_r18", member_reset, 4'b0100);
      tick();
    end
    check("m5_hi0", hi0, 17);
    check("m5_hi2", hi2, 21);
    check("m5_hi1", hi1, 0);
    check("m5_hi3", hi3, 0);
    check("m5_dones", dones, 1);
    check("m5_done_at", done_at, 22);
    check("m5_ready", req_ready, 1);

    // Zero mask: straight to DONE.
    req_mask  = 4'b0000;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("z_done", done, 1);
    check("z_busy", busy, 1);
    check("z_member_reset", member_reset, 4'b0000);
    tick();
    check("z_busy_after", busy, 0);
    check("z_done_after", done, 0);
    check("z_ready_after", req_ready, 1);

    // Held request with mask change during the sequence.
    req_mask  = 4'b0001;
    req_valid = 1'b1;
    tick();
    req_mask = 4'b0010;
    hi1 = 0;
    for (int j = 1; j <= 19; j++) begin
      if (member_reset[1]) hi1++;
      if (j == 1)  check("h_r1", member_reset, 4'b0001);
      if (j == 17) check("h_ready17", req_ready, 0);
      if (j == 18) begin
        check("h_done18", done, 1);
        check("h_ready18", req_ready, 0);
        check("h_r18", member_reset, 4'b0000);
      end
      if (j == 19) check("h_ready19", req_ready, 1);
      if (j < 19) tick();
    end
    check("h_hi1", hi1, 0);
    tick();
    check("h_second_accept", member_reset, 4'b0010);
    check("h_second_busy", busy, 1);
    req_valid = 1'b0;

    // Async reset five cycles into HOLD of the second request.
    for (int j = 0; j < 4; j++) tick();
    check("a_pre", member_reset, 4'b0010);
    #2;
    reset = 1'b1;
    #1;
    check("a_member_reset", member_reset, 4'b1111);
    check("a_busy", busy, 1);
    check("a_ready", req_ready, 0);
    check("a_done", done, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    boot_check("reboot");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
